esclavo_pintar: RTL and testbench

Round responder for the reaction game: it executes the round that the master control FSM starts and returns the round-complete handshake to it. A one-cycle `iPintar` pulse starts a round. The block latches the LFSR value, waits a pseudo-random delay, then lights the target LED and measures the player's reaction time in milliseconds. It pulses `oStop` back to the master when the round ends, and holds the result until the master's `iResetPintar` pulse clears it.

---
 rtl/esclavo_pintar.sv | 118 +++++++++++
 tb/tb_esclavo_pintar.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esclavo_pintar.sv
// Round responder for the reaction game: random delay, target LED,
// reaction time in ms, foul detection and round-complete handshake.
module esclavo_pintar #(
  parameter int TICK_DIV = 50000,
  parameter int MAX_MS   = 9999
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iPintar,
  input  logic        iResetPintar,
  input  logic [7:0]  iRandom,
  input  logic        iBoton,
  output logic        oStop,
  output logic        oLed,
  output logic [13:0] oTiempo,
  output logic        oFalta,
  output logic        oValido
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
  localparam logic [13:0] MAXV = 14'(MAX_MS);

  typedef enum logic [1:0] {
    IDLE,
    ESPERA,
    MEDIR,
    FIN
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [10:0]   dly;
  logic [13:0]   ms;
  logic          btnPrev;
  logic          press;
  logic          tick;

  assign press = iBoton & ~btnPrev;
  assign tick  = (presc == PLAST);

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      state   <= IDLE;
      presc   <= '0;
      dly     <= '0;
      ms      <= '0;
      btnPrev <= 1'b0;
      oStop   <= 1'b0;
      oLed    <= 1'b0;
      oTiempo <= '0;
      oFalta  <= 1'b0;
      oValido <= 1'b0;
    end else begin
      btnPrev <= iBoton;
      oStop   <= 1'b0;
      if (state == ESPERA || state == MEDIR)
        presc <= tick ? '0 : presc + 1'b1;
      if (iResetPintar) begin
        state   <= IDLE;
        oLed    <= 1'b0;
        oTiempo <= '0;
        oFalta  <= 1'b0;
        oValido <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (iPintar) begin
              dly   <= 11'd500 + {2'b00, iRandom, 1'b0};
              presc <= '0;
              state <= ESPERA;
            end
          end
          ESPERA: begin
            if (press) begin
              oFalta  <= 1'b1;
              oTiempo <= '0;
              oStop   <= 1'b1;
              state   <= FIN;
            end else if (tick) begin
              if (dly == 11'd1) begin
                oLed  <= 1'b1;
                ms    <= '0;
                presc <= '0;
                state <= MEDIR;
              end else begin
                dly <= dly - 1'b1;
              end
            end
          end
          MEDIR: begin
            // a press on a tick edge keeps the pre-increment count
            if (press) begin
              oTiempo <= ms;
              oValido <= 1'b1;
              oLed    <= 1'b0;
              oStop   <= 1'b1;
              state   <= FIN;
            end else if (ms >= MAXV || (tick && ms + 14'd1 >= MAXV)) begin
              ms      <= MAXV;
              oTiempo <= MAXV;
              oValido <= 1'b1;
              oLed    <= 1'b0;
              oStop   <= 1'b1;
              state   <= FIN;
            end else if (tick) begin
              ms <= ms + 14'd1;
            end
          end
          FIN: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_esclavo_pintar.sv
// Scoreboard bench for esclavo_pintar with TICK_DIV=4, MAX_MS=20.
module tb_esclavo_pintar;

  logic        iClk = 1'b0;
  logic        iReset;
  logic        iPintar;
  logic        iResetPintar;
  logic [7:0]  iRandom;
  logic        iBoton;
  logic        oStop;
  logic        oLed;
  logic [13:0] oTiempo;
  logic        oFalta;
  logic        oValido;

  typedef struct {
    logic [13:0] t;
    logic        v;
    logic        f;
  } res_t;

  res_t sb[$];
  int checks = 0;
  int errors = 0;
  int stopCount = 0;

  esclavo_pintar #(.TICK_DIV(4), .MAX_MS(20)) dut (
    .iClk(iClk),
    .iReset(iReset),
    .iPintar(iPintar),
    .iResetPintar(iResetPintar),
    .iRandom(iRandom),
    .iBoton(iBoton),
    .oStop(oStop),
    .oLed(oLed),
    .oTiempo(oTiempo),
    .oFalta(oFalta),
    .oValido(oValido)
  );

  always #5 iClk = ~iClk;

  always @(negedge iClk) if (oStop === 1'b1) stopCount++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic startRound(input logic [7:0] r);
    @(negedge iClk);
    iRandom = r;
    iPintar = 1'b1;
    @(negedge iClk);
    iPintar = 1'b0;
    iRandom = ~r;
  endtask

  task automatic waitLed(output int n);
    n = 0;
    while (oLed !== 1'b1 && n < 5000) begin
      @(negedge iClk);
      n++;
    end
  endtask

  task automatic waitStop(output int lat);
    lat = 0;
    while (oStop !== 1'b1 && lat < 300) begin
      @(negedge iClk);
      lat++;
    end
    if (oStop !== 1'b1) lat = -1;
  endtask

  task automatic clearRound();
    @(negedge iClk);
    iResetPintar = 1'b1;
    @(negedge iClk);
    iResetPintar = 1'b0;
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    iPintar = 1'b0;
    iResetPintar = 1'b0;
    iRandom = 8'h00;
    iBoton = 1'b0;
    #3 iReset = 1'b0;
    #1;
    checks++;
    if ({oStop, oLed, oFalta, oValido} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000",
               {oStop, oLed, oFalta, oValido});
    end
    checks++;
    if (oTiempo !== 14'd0) begin
      errors++;
      $display("FAIL reset_tiempo got %0d want 0", oTiempo);
    end
    repeat (2) @(negedge iClk);
    iReset = 1'b1;
  endtask

  task automatic test_normal();
    int n, lat, s0;
    res_t e;
    startRound(8'h00);
    waitLed(n);
    checks++;
    if (n !== 2000) begin
      errors++;
      $display("FAIL normal_led_latency got %0d want 2000", n);
    end
    repeat (28) @(negedge iClk);
    s0 = stopCount;
    iBoton = 1'b1;
    sb.push_back('{t: 14'd7, v: 1'b1, f: 1'b0});
    waitStop(lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL normal_stop_latency got %0d want 1", lat);
    end
    e = sb.pop_front();
    checks++;
    if (oTiempo !== e.t || oValido !== e.v || oFalta !== e.f) begin
      errors++;
      $display("FAIL normal_result got t=%0d v=%b f=%b want t=%0d v=%b f=%b",
               oTiempo, oValido, oFalta, e.t, e.v, e.f);
    end
    checks++;
    if (oLed !== 1'b0) begin
      errors++;
      $display("FAIL normal_led_off got %b want 0", oLed);
    end
    repeat (3) @(negedge iClk);
    checks++;
    if (stopCount - s0 !== 1) begin
      errors++;
      $display("FAIL normal_stop_count got %0d want 1", stopCount - s0);
    end
    iBoton = 1'b0;
    clearRound();
  endtask

  task automatic test_max_delay();
    int n, s0;
    startRound(8'hFF);
    waitLed(n);
    checks++;
    if (n !== 4040) begin
      errors++;
      $display("FAIL maxdly_led_latency got %0d want 4040", n);
    end
    s0 = stopCount;
    repeat (10) @(negedge iClk);
    clearRound();
    checks++;
    if (oLed !== 1'b0 || oValido !== 1'b0) begin
      errors++;
      $display("FAIL maxdly_clear got led=%b v=%b want 0 0", oLed, oValido);
    end
    repeat (100) @(negedge iClk);
    checks++;
    if (stopCount !== s0 || oLed !== 1'b0) begin
      errors++;
      $display("FAIL maxdly_no_stop got stops=%0d led=%b want 0 0",
               stopCount - s0, oLed);
    end
  endtask

  task automatic test_early_press();
    int lat, s0;
    res_t e;
    startRound(8'h05);
    repeat (50) @(negedge iClk);
    s0 = stopCount;
    iBoton = 1'b1;
    sb.push_back('{t: 14'd0, v: 1'b0, f: 1'b1});
    waitStop(lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL early_stop_latency got %0d want 1", lat);
    end
    e = sb.pop_front();
    checks++;
    if (oTiempo !== e.t || oValido !== e.v || oFalta !== e.f) begin
      errors++;
      $display("FAIL early_result got t=%0d v=%b f=%b want t=%0d v=%b f=%b",
               oTiempo, oValido, oFalta, e.t, e.v, e.f);
    end
    iBoton = 1'b0;
    repeat (2500) @(negedge iClk);
    checks++;
    if (oLed !== 1'b0 || oFalta !== 1'b1) begin
      errors++;
      $display("FAIL early_hold got led=%b f=%b want 0 1", oLed, oFalta);
    end
    checks++;
    if (stopCount - s0 !== 1) begin
      errors++;
      $display("FAIL early_stop_count got %0d want 1", stopCount - s0);
    end
    clearRound();
  endtask

  task automatic test_timeout();
    int n, lat;
    res_t e;
    startRound(8'h00);
    waitLed(n);
    sb.push_back('{t: 14'd20, v: 1'b1, f: 1'b0});
    waitStop(lat);
    checks++;
    if (lat !== 80) begin
      errors++;
      $display("FAIL timeout_latency got %0d want 80", lat);
    end
    e = sb.pop_front();
    checks++;
    if (oTiempo !== e.t || oValido !== e.v || oFalta !== e.f || oLed !== 1'b0) begin
      errors++;
      $display("FAIL timeout_result got t=%0d v=%b f=%b led=%b want t=%0d v=%b f=%b led=0",
               oTiempo, oValido, oFalta, oLed, e.t, e.v, e.f);
    end
    clearRound();
  endtask

  task automatic test_held_and_clear();
    int n, lat, s0;
    res_t e;
    @(negedge iClk);
    iBoton = 1'b1;
    repeat (2) @(negedge iClk);
    startRound(8'h00);
    waitLed(n);
    checks++;
    if (n !== 2000 || oFalta !== 1'b0) begin
      errors++;
      $display("FAIL held_no_foul got n=%0d f=%b want 2000 0", n, oFalta);
    end
    iBoton = 1'b0;
    s0 = stopCount;
    repeat (5) @(negedge iClk);
    iRandom = 8'd77;
    iPintar = 1'b1;
    @(negedge iClk);
    iPintar = 1'b0;
    checks++;
    if (oLed !== 1'b1 || stopCount !== s0) begin
      errors++;
      $display("FAIL ignored_start got led=%b stops=%0d want 1 0",
               oLed, stopCount - s0);
    end
    repeat (6) @(negedge iClk);
    iBoton = 1'b1;
    sb.push_back('{t: 14'd3, v: 1'b1, f: 1'b0});
    waitStop(lat);
    e = sb.pop_front();
    checks++;
    if (lat !== 1 || oTiempo !== e.t || oValido !== e.v || oFalta !== e.f) begin
      errors++;
      $display("FAIL held_result got lat=%0d t=%0d v=%b f=%b want 1 %0d %b %b",
               lat, oTiempo, oValido, oFalta, e.t, e.v, e.f);
    end
    iBoton = 1'b0;
    repeat (20) @(negedge iClk);
    checks++;
    if (oValido !== 1'b1 || oTiempo !== 14'd3 || stopCount - s0 !== 1) begin
      errors++;
      $display("FAIL fin_hold got v=%b t=%0d stops=%0d want 1 3 1",
               oValido, oTiempo, stopCount - s0);
    end
    clearRound();
    checks++;
    if ({oStop, oLed, oFalta, oValido} !== 4'b0000 || oTiempo !== 14'd0) begin
      errors++;
      $display("FAIL clear_outputs got %b t=%0d want 0000 0",
               {oStop, oLed, oFalta, oValido}, oTiempo);
    end
    repeat (100) @(negedge iClk);
    checks++;
    if (oLed !== 1'b0 || stopCount - s0 !== 1) begin
      errors++;
      $display("FAIL clear_idle got led=%b stops=%0d want 0 1",
               oLed, stopCount - s0);
    end
  endtask

  task automatic test_abort();
    int n, s0;
    startRound(8'h00);
    waitLed(n);
    repeat (10) @(negedge iClk);
    s0 = stopCount;
    #2 iReset = 1'b0;
    #1;
    checks++;
    if (oLed !== 1'b0 || oValido !== 1'b0) begin
      errors++;
      $display("FAIL abort_async got led=%b v=%b want 0 0", oLed, oValido);
    end
    repeat (20) @(negedge iClk);
    iReset = 1'b1;
    repeat (20) @(negedge iClk);
    checks++;
    if (stopCount !== s0 || oLed !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_stop got stops=%0d led=%b want 0 0",
               stopCount - s0, oLed);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_max_delay();
    test_early_press();
    test_timeout();
    test_held_and_clear();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
